// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
package sync_fifo_pkg;

  function automatic int depth(int addrsize);
    return 1 << addrsize;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of sync_fifo; the FIFO is the slave.
interface sync_fifo_if #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
);
  logic                flush;
  logic                clr_err;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                wfull;
  logic                walmost_full;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                ralmost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport slave (
    input  flush, clr_err, winc, wdata, rinc,
    output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );

  modport master (
    output flush, clr_err, winc, wdata, rinc,
    input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one read port that is registered,
// or combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4
) (
  input  logic                clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                rst,
  input  logic                re_i,
`endif
  input  logic                we_i,
  input  logic [ADDRSIZE-1:0] waddr_i,
  input  logic [DATASIZE-1:0] wdata_i,
  input  logic [ADDRSIZE-1:0] raddr_i,
  output logic [DATASIZE-1:0] rdata_o
);
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  logic [DATASIZE-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o = mem_q[raddr_i];
`else
  logic [DATASIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
`endif
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags, sticky errors and flush.
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned AF_MARGIN = 2,
  parameter int unsigned AE_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);
  localparam int unsigned DEPTH = depth(ADDRSIZE);
  localparam int unsigned PW    = ADDRSIZE + 1;

  if (AF_MARGIN >= DEPTH) begin : g_af_chk
    $error("sync_fifo: AF_MARGIN must be smaller than the depth");
  end
  if (AE_MARGIN >= DEPTH) begin : g_ae_chk
    $error("sync_fifo: AE_MARGIN must be smaller than the depth");
  end

  logic [PW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [PW-1:0] count_c;
  fifo_err_t     err_q, err_d;
  logic          full_c, empty_c, wr_en_c, rd_en_c;

  assign count_c = waddr_q - raddr_q;
  assign full_c  = (count_c == PW'(DEPTH));
  assign empty_c = (count_c == '0);
  assign wr_en_c = bus.winc && !full_c  && !bus.flush;
  assign rd_en_c = bus.rinc && !empty_c && !bus.flush;

  // Next state: flush beats accesses; a fresh error beats clr_err
  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    if (bus.flush) begin
      waddr_d = '0;
      raddr_d = '0;
    end else begin
      if (wr_en_c) waddr_d = waddr_q + PW'(1);
      if (rd_en_c) raddr_d = raddr_q + PW'(1);
    end
    err_d.overflow  = (bus.winc && full_c  && !bus.flush) || (err_q.overflow  && !bus.clr_err);
    err_d.underflow = (bus.rinc && empty_c && !bus.flush) || (err_q.underflow && !bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      raddr_q <= '0;
      err_q   <= '0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
    end
  end

  sync_fifo_mem #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_mem (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .rst     (rst),
    .re_i    (rd_en_c),
`endif
    .we_i    (wr_en_c),
    .waddr_i (waddr_q[ADDRSIZE-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (raddr_q[ADDRSIZE-1:0]),
    .rdata_o (bus.rdata)
  );

  assign bus.count         = count_c;
  assign bus.wfull         = full_c;
  assign bus.rempty        = empty_c;
  assign bus.walmost_full  = (count_c >= PW'(DEPTH - AF_MARGIN));
  assign bus.ralmost_empty = (count_c <= PW'(AE_MARGIN));
  assign bus.overflow      = err_q.overflow;
  assign bus.underflow     = err_q.underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  sync_fifo #(
    .DATASIZE  (DW),
    .ADDRSIZE  (AW),
    .AF_MARGIN (2),
    .AE_MARGIN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: contents as a queue, plus error flags and last popped word
  logic [DW-1:0] mq [$];
  fifo_err_t     merr;
  logic [DW-1:0] mrd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("count",         32'(bus.count),         32'(mq.size()));
    check("wfull",         32'(bus.wfull),         32'(mq.size() == DEPTH));
    check("rempty",        32'(bus.rempty),        32'(mq.size() == 0));
    check("walmost_full",  32'(bus.walmost_full),  32'(mq.size() >= DEPTH - 2));
    check("ralmost_empty", 32'(bus.ralmost_empty), 32'(mq.size() <= 2));
    check("overflow",      32'(bus.overflow),      32'(merr.overflow));
    check("underflow",     32'(bus.underflow),     32'(merr.underflow));
`ifdef SYNC_FIFO_FWFT_EN
    if (mq.size() > 0) check("rdata_head", 32'(bus.rdata), 32'(mq[0]));
`else
    check("rdata", 32'(bus.rdata), 32'(mrd));
`endif
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic step(input logic r, input logic f, input logic c, input logic w,
                      input logic [DW-1:0] d, input logic rd);
    bit full, empty, new_o, new_u;
    rst = r; bus.flush = f; bus.clr_err = c; bus.winc = w; bus.wdata = d; bus.rinc = rd;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (r) begin
      mq.delete(); merr = '0; mrd = '0;
    end else if (f) begin
      mq.delete();
      if (c) merr = '0;
    end else begin
      new_o = w && full;
      new_u = rd && empty;
      if (rd && !empty) mrd = mq.pop_front();
      if (w && !full) mq.push_back(d);
      merr.overflow  = new_o || (merr.overflow  && !c);
      merr.underflow = new_u || (merr.underflow && !c);
    end
    @(posedge clk);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic          rst, flush, clr, winc;
    logic [DW-1:0] wdata;
    logic          rinc;
    logic [AW:0]   exp_count;
    logic          exp_empty, exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [DW-1:0] exp_rd;
    rst = 1'b1; bus.flush = 0; bus.clr_err = 0; bus.winc = 0; bus.wdata = '0; bus.rinc = 0;
    merr = '0; mrd = '0;

    //         rst flush clr winc wdata  rinc  cnt empty ovf unf
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].clr, vecs[i].winc, vecs[i].wdata, vecs[i].rinc);
      check($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vecs[i].exp_count));
      check($sformatf("vec%0d_empty", i), 32'(bus.rempty),    32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_ovf", i),   32'(bus.overflow),  32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i),   32'(bus.underflow), 32'(vecs[i].exp_unf));
    end

    // Fill 0x00..0x0F, then overflow with 0xAA, then clear the error
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, DW'(i), 0);
      check("fill_count", 32'(bus.count),        32'(i + 1));
      check("fill_af",    32'(bus.walmost_full), 32'(i + 1 >= 14));
    end
    check("fill_full", 32'(bus.wfull), 32'd1);
    step(0, 0, 0, 1, 8'hAA, 0);
    check("ovf_count", 32'(bus.count),    32'd16);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    step(0, 0, 1, 0, 8'h00, 0);
    check("ovf_clr",   32'(bus.overflow), 32'd0);

    // Drain: data must come out 0x00..0x0F, never 0xAA
    for (int i = 0; i < 16; i++) begin
      exp_rd = DW'(i);
`ifdef SYNC_FIFO_FWFT_EN
      check("drain_head", 32'(bus.rdata), 32'(exp_rd));
      step(0, 0, 0, 0, 8'h00, 1);
`else
      step(0, 0, 0, 0, 8'h00, 1);
      check("drain_rdata", 32'(bus.rdata), 32'(exp_rd));
`endif
      check("drain_ae", 32'(bus.ralmost_empty), 32'(15 - i <= 2));
    end
    check("drain_empty", 32'(bus.rempty), 32'd1);

    // Wrap: steady occupancy of 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, DW'(8'h80 + i), 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 1, DW'(8'h90 + i), 1);
      check("wrap_count", 32'(bus.count), 32'd3);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 1);

    // Flush at count 9 together with a write
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, DW'(8'hC0 + i), 0);
    step(0, 1, 0, 1, 8'hEE, 0);
    check("flush_count", 32'(bus.count),    32'd0);
    check("flush_empty", 32'(bus.rempty),   32'd1);
    check("flush_ovf",   32'(bus.overflow), 32'd0);

    // Reset at count 9 together with a write
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, DW'(8'hD0 + i), 0);
    step(1, 0, 0, 1, 8'hEF, 0);
    check("rst_count", 32'(bus.count),         32'd0);
    check("rst_ae",    32'(bus.ralmost_empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdata", 32'(bus.rdata), 32'd0);
`endif

    // Random traffic with slowly drifting write/read bias
    for (int i = 0; i < 3000; i++) begin
      int unsigned wp, rp;
      logic r, f, c;
      wp = ((i / 200) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 99) < 2);
      c  = !f && ($urandom_range(0, 99) < 5);
      step(r, f, c, $urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < rp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the successor to the dual-clock `fifo`. It is used wherever producer and consumer share one clock. It adds three things over that generation:
- occupancy count, almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a flush control.

An optional first-word-fall-through read mode is selected at compile time.

## Interface
- `DATASIZE`, 8, data word width in bits
- `ADDRSIZE`, 4, address width; depth = 2**ADDRSIZE entries
- `AF_MARGIN`, 2, `walmost_full` asserts when free entries <= AF_MARGIN
- `AE_MARGIN`, 2, `ralmost_empty` asserts when occupancy <= AE_MARGIN
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `flush`  in  1  synchronous empty request
- `clr_err`  in  1  clears sticky error flags
- `winc`  in  1  write request
- `wdata`  in  DATASIZE  write data
- `wfull`  out  1  FIFO holds 2**ADDRSIZE entries
- `walmost_full`  out  1  almost-full flag
- `rinc`  in  1  read request
- `rdata`  out  DATASIZE  read data
- `rempty`  out  1  FIFO holds 0 entries
- `ralmost_empty`  out  1  almost-empty flag
- `count`  out  ADDRSIZE+1  current occupancy, 0 to 2**ADDRSIZE
- `overflow`  out  1  sticky: write attempted while full
- `underflow`  out  1  sticky: read attempted while empty

## Operation
- **Pointers:** `waddr` and `raddr` are ADDRSIZE+1 bits wide, binary, and wrap naturally mod 2**(ADDRSIZE+1).
- **Occupancy:** `count = waddr - raddr`, computed mod 2**(ADDRSIZE+1).
- **Flag decode from count:**
  - `wfull = (count == 2**ADDRSIZE)`
  - `rempty = (count == 0)`
  - `walmost_full = (count >= 2**ADDRSIZE - AF_MARGIN)`
  - `ralmost_empty = (count <= AE_MARGIN)`
- **Write:** accepted when `winc && !wfull`. It stores `wdata` at `waddr[ADDRSIZE-1:0]` and increments `waddr`.
- **Rejected write:** `winc && wfull` leaves contents untouched and sets `overflow`. A same-cycle `rinc` does not make room.
- **Read:** accepted when `rinc && !rempty`; it increments `raddr`.
- **Rejected read:** `rinc && rempty` changes nothing and sets `underflow`. A same-cycle write does not satisfy it.
- **Simultaneous accepted read and write:** `count` is unchanged; both pointers advance.
- **Priority** per edge: `rst` > `flush` > accesses.
  - `flush`: both pointers go to 0 and `rdata` is held. Same-cycle `winc`/`rinc` are ignored and set no error flag.
- **Error flags:** `clr_err` clears `overflow`/`underflow`. A new error in the same cycle wins (flag stays 1).
- **Reset values:** pointers 0, `count` 0, `rempty` 1, `ralmost_empty` 1, `wfull` 0, `walmost_full` 0, `overflow` 0, `underflow` 0, `rdata` 0.
  - Memory contents are not reset.
  - Reset mid-traffic discards all entries.
- **Parameter legality:** AF_MARGIN and AE_MARGIN must each be < 2**ADDRSIZE; checked with an elaboration-time assertion.

## Timing
- Flags and `count` are decoded from registered pointers. They reflect an access on the edge at which it is accepted, visible in the following cycle.
- Write-to-read latency: a word written at edge N can be popped at edge N+1 (`rempty` falls after edge N).
- Standard mode `rdata`: registered, loaded at the edge accepting a read, valid from the following cycle. It holds its value otherwise, including on rejected reads.
- Data capture (both modes): `wdata` is sampled only on the accepting edge.

## Configuration
- Macro: `SYNC_FIFO_FWFT_EN`.
- **Defined (first-word-fall-through):**
  - `rdata` is a combinational read of the head entry `mem[raddr]`.
  - It is valid whenever `rempty = 0`, so the first word is visible the cycle after it is written.
  - The edge with `rinc && !rempty` advances to the next word.
  - `rdata` is don't-care while `rempty = 1`.
- **Undefined:** standard registered read as described under Timing; `rdata` resets to 0.

## Structure
- **Package `sync_fifo_pkg`:**
  - `function automatic int depth(int addrsize)`
  - typedef `fifo_err_t` struct {`overflow`, `underflow`}, shared with the bench scoreboard
- **Sub-module `sync_fifo_mem`:** 2**ADDRSIZE x DATASIZE array.
  - One synchronous write port.
  - One read port, registered or combinational selected by `SYNC_FIFO_FWFT_EN`.
- **Top:** pointers, count, flags and error logic.

## Test plan
All cases use defaults (DATASIZE 8, ADDRSIZE 4, depth 16, margins 2).
- **Fill/drain:**
  - Write 0x00..0x0F → `wfull` = 1 and `count` = 16 after the 16th write; `walmost_full` is 1 from `count` = 14.
  - Read 16 → `rdata` sequence 0x00..0x0F, `rempty` = 1, `ralmost_empty` = 1 once `count` <= 2.
- **Overflow:** full FIFO, `winc` with `wdata` = 0xAA → `count` stays 16, `overflow` = 1, and 0xAA never appears on `rdata`.
  - Then `clr_err` → `overflow` = 0.
- **Underflow:** empty FIFO, `rinc` + `winc` (0x5A) in the same cycle → `underflow` = 1, `count` = 1; the next read returns 0x5A.
- **Wrap:** 40 interleaved write/read pairs at steady `count` 3 → pointers wrap past 31, data order intact, `count` constant at 3.
- **Flush/reset:** `count` = 9, assert `flush` together with `winc` → `count` = 0, `rempty` = 1, no error flags.
  - Repeat the scenario with `rst` → every output at its listed reset value.
